hoop_shot_detector: RTL

- Upstream of the score counter and leaderboard path; converts the three raw hoop switch inputs into clean, single-cycle scoring events.
- Per-channel processing: synchronizes each raw input, debounces it, detects its rising edge, and applies a post-score holdoff.
- Gated by the game-active window from the countdown timer.
- Maintains a saturating two-digit shot total for the display and leaderboard.

---
 rtl/hoop_shot_detector_pkg.sv | 23 ++
 rtl/hoop_shot_detector_sensor_debounce.sv | 51 +++++
 rtl/hoop_shot_detector.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hoop_shot_detector_pkg.sv
// Shared types and constants for the hoop shot detector.
// Point values and the saturating score helper live here.
package hoop_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [1:0] POINTS_CH0 = 2'd1;
    localparam logic [1:0] POINTS_CH1 = 2'd2;
    localparam logic [1:0] POINTS_CH2 = 2'd3;
    localparam logic [7:0] SCORE_MAX  = 8'd99;

    // 9-bit sum so an overflow past 255 could never wrap before the clamp.
    function automatic logic [7:0] sat_add(input logic [7:0] total, input logic [1:0] pts);
        logic [8:0] sum;
        sum = {1'b0, total} + {7'b0, pts};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/hoop_shot_detector_sensor_debounce.sv
// One hoop switch channel: 2-flop synchronizer, stability counter and
// the debounced level register.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clean_q;
    logic          clean_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    // Toggle on the cycle the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = ~clean_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/hoop_shot_detector.sv
// Turns three raw hoop switches into single-cycle scoring strobes, gated by
// the game window, with a post-score holdoff and a saturating points total.
module hoop_shot_detector
    import hoop_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLDOFF_CYCLES  = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] sensor_in,
    input  logic       game_active,
    output logic       score_pulse,
    output logic [1:0] score_points,
    output logic [7:0] shot_count,
    output logic [2:0] sensor_clean,
    output logic       holdoff
);

    localparam int unsigned HCW = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLDOFF_CYCLES);

    logic [2:0]     clean;
    logic [2:0]     clean_prev_q;
    logic [2:0]     rise;
    logic [1:0]     rise_points;
    logic           game_prev_q;
    logic           game_rise;

    state_t         state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           pulse_q, pulse_d;
    logic [1:0]     points_q, points_d;
    logic [7:0]     count_q, count_d;
    logic           holdoff_q, holdoff_d;

    for (genvar i = 0; i < 3; i++) begin : g_chan
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (sensor_in[i]),
            .clean(clean[i])
        );
    end

    assign rise      = clean & ~clean_prev_q;
    assign game_rise = game_active & ~game_prev_q;

    always_comb begin
        rise_points = 2'd0;
        if (rise[2]) begin
            rise_points = POINTS_CH2;
        end else if (rise[1]) begin
            rise_points = POINTS_CH1;
        end else if (rise[0]) begin
            rise_points = POINTS_CH0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clean_prev_q <= 3'b000;
            game_prev_q  <= 1'b0;
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            pulse_q      <= 1'b0;
            points_q     <= 2'd0;
            count_q      <= 8'd0;
            holdoff_q    <= 1'b0;
        end else begin
            clean_prev_q <= clean;
            game_prev_q  <= game_active;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            pulse_q      <= pulse_d;
            points_q     <= points_d;
            count_q      <= count_d;
            holdoff_q    <= holdoff_d;
        end
    end

    // game_active low always wins over a coincident edge.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pulse_d    = 1'b0;
        points_d   = 2'd0;
        count_d    = count_q;
        unique case (state_q)
            IDLE: begin
                if (game_rise) begin
                    count_d = 8'd0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!game_active) begin
                    state_d = IDLE;
                end else if (|rise) begin
                    pulse_d    = 1'b1;
                    points_d   = rise_points;
                    count_d    = sat_add(count_q, rise_points);
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!game_active) begin
                    state_d = IDLE;
                end else if (hold_cnt_q == '0) begin
                    state_d = ARMED;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The pulse cycle is excluded so holdoff spans exactly HOLDOFF_CYCLES.
        holdoff_d = (state_q == HOLDOFF) && (state_d == HOLDOFF);
    end

    assign score_pulse  = pulse_q;
    assign score_points = points_q;
    assign shot_count   = count_q;
    assign sensor_clean = clean;
    assign holdoff      = holdoff_q;

endmodule
